fp_recip_iter: RTL



---
 rtl/fp_recip_if.sv | 23 ++
 rtl/fp_recip_iter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_recip_if.sv
// Operand/result handshake bundle for the iterative reciprocal engine.
// master = operand source and result consumer; slave = the engine.
interface fp_recip_if #(
    parameter int DATA_W = 64
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        out_flags;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flags
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flags
    );
endinterface

// File: rtl/fp_recip_iter.sv
// Sequential IEEE-754 reciprocal: LUT seed, then NR_ITERS Newton-Raphson steps
// on one shared multiplier; result truncated (RZ), flags {nv, dz, uf}.
//
// state | meaning
// IDLE  | ready for an operand; specials and powers of two resolved at accept
// SEED  | load y0 from the seed table
// MUL_A | t = 2 - x*y
// MUL_B | y = y*t, count iteration
// NORM  | form exponent/fraction from y, flush underflow to zero
// DONE  | result valid, held until out_ready
module fp_recip_iter #(
    parameter int EXP_W    = 11,
    parameter int MANT_W   = 52,
    parameter int LUT_BITS = 8,
    parameter int NR_ITERS = 3
) (
    input logic       clk,
    input logic       rst_n,
    fp_recip_if.slave io
);
    localparam int DW    = EXP_W + MANT_W + 1;
    localparam int W     = MANT_W + 4;
    localparam int YW    = W + 1;
    localparam int OPW   = W + 2;
    localparam int PW    = 2 * OPW;
    localparam int NUMW  = W + LUT_BITS + 3;
    localparam int LUT_N = 1 << LUT_BITS;
    localparam int CNT_W = (NR_ITERS < 1) ? 1 : $clog2(NR_ITERS + 1);
    localparam logic [EXP_W-1:0] BIAS2 = EXP_W'((1 << EXP_W) - 2);

    if (LUT_BITS * (1 << NR_ITERS) < MANT_W + 2) begin : g_bad_iters
        $error("fp_recip_iter: LUT_BITS*2^NR_ITERS must be >= MANT_W+2");
    end
    if (LUT_BITS > MANT_W) begin : g_bad_lut
        $error("fp_recip_iter: LUT_BITS must not exceed MANT_W");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEED  = 3'd1,
        MUL_A = 3'd2,
        MUL_B = 3'd3,
        NORM  = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nx;

    // Seed for bucket i is the reciprocal of the bucket midpoint, rounded to W bits.
    function automatic logic [YW-1:0] seed_calc(input int idx);
        logic [NUMW-1:0] num;
        logic [NUMW-1:0] den;
        num = '0;
        num[W + LUT_BITS + 1] = 1'b1;
        den = NUMW'((2 << LUT_BITS) + 2 * idx + 1);
        return YW'((num + (den >> 1)) / den);
    endfunction

    logic [YW-1:0] seed_rom [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_rom
        assign seed_rom[g] = seed_calc(g);
    end

    logic              in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MANT_W-1:0] in_frac;
    assign {in_sign, in_exp, in_frac} = io.in_data;

    logic              sign_q;
    logic [EXP_W-1:0]  exp_q;
    logic [MANT_W-1:0] frac_q;
    logic [YW-1:0]     y_q;
    logic [OPW-1:0]    t_q;
    logic [CNT_W-1:0]  iter_cnt;
    logic [DW-1:0]     out_data_q;
    logic [2:0]        out_flags_q;

    logic              fast_hit;
    logic [DW-1:0]     fast_data;
    logic [2:0]        fast_flags;
    logic [EXP_W-1:0]  pow2_exp;

    always_comb begin
        fast_hit   = 1'b1;
        fast_data  = '0;
        fast_flags = '0;
        pow2_exp   = BIAS2 - in_exp;
        if (&in_exp) begin
            if (|in_frac) begin
                fast_data  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
                fast_flags = 3'b100;
            end else begin
                fast_data = {in_sign, {(DW-1){1'b0}}};
            end
        end else if (in_exp == '0) begin
            fast_data  = {in_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            fast_flags = 3'b010;
        end else if (in_frac == '0) begin
            if (pow2_exp == '0) begin
                fast_data  = {in_sign, {(DW-1){1'b0}}};
                fast_flags = 3'b001;
            end else begin
                fast_data = {in_sign, pow2_exp, {MANT_W{1'b0}}};
            end
        end else begin
            fast_hit = 1'b0;
        end
    end

    // One multiplier serves both steps: x*y in MUL_A, y*t otherwise.
    logic [OPW-1:0] mul_a;
    logic [OPW-1:0] mul_b;
    logic [PW-1:0]  prod;
    logic [OPW-1:0] t_next;
    logic           unused_bits;

    assign mul_a  = (state == MUL_A) ? OPW'({1'b1, frac_q}) : OPW'(y_q);
    assign mul_b  = (state == MUL_A) ? OPW'(y_q) : t_q;
    assign prod   = {{OPW{1'b0}}, mul_a} * {{OPW{1'b0}}, mul_b};
    assign t_next = {2'b10, {W{1'b0}}} - prod[MANT_W +: OPW];
    assign unused_bits = ^{prod[MANT_W-1:0], prod[PW-1:2*W+1]};

    logic [EXP_W:0] norm_exp;
    logic           norm_uf;
    assign norm_exp = {1'b0, BIAS2} - {1'b0, exp_q} - (EXP_W+1)'(1);
    assign norm_uf  = norm_exp[EXP_W] | (norm_exp == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (io.in_valid) state_nx = fast_hit ? DONE : SEED;
            SEED:    state_nx = MUL_A;
            MUL_A:   state_nx = MUL_B;
            MUL_B:   state_nx = (iter_cnt + CNT_W'(1) < CNT_W'(NR_ITERS)) ? MUL_A : NORM;
            NORM:    state_nx = DONE;
            DONE:    if (io.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_q      <= 1'b0;
            exp_q       <= '0;
            frac_q      <= '0;
            y_q         <= '0;
            t_q         <= '0;
            iter_cnt    <= '0;
            out_data_q  <= '0;
            out_flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        sign_q <= in_sign;
                        exp_q  <= in_exp;
                        frac_q <= in_frac;
                        if (fast_hit) begin
                            out_data_q  <= fast_data;
                            out_flags_q <= fast_flags;
                        end
                    end
                end
                SEED: begin
                    y_q      <= seed_rom[frac_q[MANT_W-1 -: LUT_BITS]];
                    iter_cnt <= '0;
                end
                MUL_A: t_q <= t_next;
                MUL_B: begin
                    y_q      <= prod[W +: YW];
                    iter_cnt <= iter_cnt + CNT_W'(1);
                end
                NORM: begin
                    // y lies in (0.5,1): its leading one sits at bit W-1.
                    if (norm_uf) begin
                        out_data_q  <= {sign_q, {(DW-1){1'b0}}};
                        out_flags_q <= 3'b001;
                    end else begin
                        out_data_q  <= {sign_q, norm_exp[EXP_W-1:0], y_q[W-2 -: MANT_W]};
                        out_flags_q <= 3'b000;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.out_data  = out_data_q;
    assign io.out_flags = out_flags_q;
endmodule
